// File: rtl/os_tx_scheduler.sv
// rtl/os_tx_scheduler.sv - PIPE transmit scheduler for ordered sets, SKP insertion and packet streams
//
// Purpose: arbitrates the lane datapath between LTSSM ordered sets (TS1/TS2/EIOS),
//          periodic SKP ordered sets and the TLP/DLLP packet stream. All outputs registered.
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   gen[2:0]            current generation (selects ordered-set length)
//   linkUp              link trained; enables packets and the SKP timer
//   osReq, osType[1:0]  LTSSM ordered-set request (level) and type
//   pktReq, pktEnd      packet stream request and last-cycle marker
//   osStart, osActive   first cycle / every cycle of an ordered set
//   osSel[1:0]          type of the set being driven
//   osAck               last cycle of an LTSSM-requested set
//   pktGrant            packet stream owns the datapath
//   skpPending          a scheduled SKP has not been sent yet
// Options: OS_SKP_DEBT_EN - count up to 3 owed SKPs instead of a single pending flag.
module os_tx_scheduler #(
   parameter int GEN1_PIPEWIDTH = 64,
   parameter int GENX_PIPEWIDTH = 8,
   parameter int SKP_INTERVAL   = 1180
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] gen,
   input  logic       linkUp,
   input  logic       osReq,
   input  logic [1:0] osType,
   input  logic       pktReq,
   input  logic       pktEnd,
   output logic       osStart,
   output logic       osActive,
   output logic [1:0] osSel,
   output logic       osAck,
   output logic       pktGrant,
   output logic       skpPending
);
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_SEND_OS  = 2'd1;
   localparam logic [1:0] ST_SEND_SKP = 2'd2;
   localparam logic [1:0] ST_PKT      = 2'd3;

   localparam logic [1:0]  OS_SKP     = 2'b10;
   localparam logic [7:0]  LEN_GEN1   = 8'(128 / GEN1_PIPEWIDTH);
   localparam logic [7:0]  LEN_GENX   = 8'(128 / GENX_PIPEWIDTH);
   localparam logic [11:0] TIMER_LAST = 12'(SKP_INTERVAL - 1);

   logic [1:0]  r_state;
   logic [7:0]  r_cnt;
   logic [7:0]  r_len;
   logic [11:0] r_timer;
   logic [1:0]  r_sel;
   logic        r_start;
   logic        r_active;
   logic        r_ack;
   logic        r_grant;
   logic        r_pend;

   logic [1:0]  w_state_nxt;
   logic [7:0]  w_cnt_nxt;
   logic [7:0]  w_len_nxt;
   logic [1:0]  w_sel_nxt;
   logic [7:0]  w_len_gen;
   logic        w_expire;
   logic        w_last;
   logic        w_skp_done;
   logic        w_pend_nxt;

   // Unused generation codes fall back to the gen1 width.
   assign w_len_gen = (gen >= 3'b010 && gen <= 3'b101) ? LEN_GENX : LEN_GEN1;
   assign w_expire  = linkUp && (r_timer == TIMER_LAST);
   assign w_last    = (r_cnt == r_len);

   // r_cnt numbers the cycles of a set 1..r_len; 0 outside a set.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_len_nxt   = r_len;
      w_sel_nxt   = r_sel;
      case (r_state)
         ST_IDLE: begin
            if (r_pend && linkUp) begin
               w_state_nxt = ST_SEND_SKP;
               w_cnt_nxt   = 8'd1;
               w_len_nxt   = w_len_gen;
               w_sel_nxt   = OS_SKP;
            end else if (osReq) begin
               w_state_nxt = ST_SEND_OS;
               w_cnt_nxt   = 8'd1;
               w_len_nxt   = w_len_gen;
               w_sel_nxt   = osType;
            end else if (pktReq && linkUp) begin
               w_state_nxt = ST_PKT;
            end
         end
         ST_SEND_OS: begin
            // An LTSSM set always runs to completion, even across a link drop.
            if (w_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         ST_SEND_SKP: begin
            if (!linkUp || w_last) begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = 8'd0;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
         end
         default: begin
            if (pktEnd || !linkUp) begin
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   // The SKP counts as sent when the registered outputs move into its last cycle.
   assign w_skp_done = (w_state_nxt == ST_SEND_SKP) && (w_cnt_nxt == w_len_nxt);

`ifdef OS_SKP_DEBT_EN
   logic [1:0] r_debt;
   logic [1:0] w_debt_nxt;

   // A completion and an expiry on the same edge cancel out.
   always_comb begin
      w_debt_nxt = r_debt;
      if (!linkUp) begin
         w_debt_nxt = 2'd0;
      end else if (w_expire && !w_skp_done) begin
         if (r_debt != 2'd3) begin
            w_debt_nxt = r_debt + 2'd1;
         end
      end else if (!w_expire && w_skp_done) begin
         w_debt_nxt = r_debt - 2'd1;
      end
   end

   assign w_pend_nxt = (w_debt_nxt != 2'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_debt <= 2'd0;
      end else begin
         r_debt <= w_debt_nxt;
      end
   end
`else
   // Expiry wins over completion so a coincident expiry keeps the flag set.
   always_comb begin
      w_pend_nxt = r_pend;
      if (!linkUp) begin
         w_pend_nxt = 1'b0;
      end else if (w_expire) begin
         w_pend_nxt = 1'b1;
      end else if (w_skp_done) begin
         w_pend_nxt = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 8'd0;
         r_len    <= 8'd0;
         r_timer  <= 12'd0;
         r_sel    <= 2'b00;
         r_start  <= 1'b0;
         r_active <= 1'b0;
         r_ack    <= 1'b0;
         r_grant  <= 1'b0;
         r_pend   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_len    <= w_len_nxt;
         r_sel    <= w_sel_nxt;
         r_start  <= (r_state == ST_IDLE) &&
                     ((w_state_nxt == ST_SEND_OS) || (w_state_nxt == ST_SEND_SKP));
         r_active <= (w_state_nxt == ST_SEND_OS) || (w_state_nxt == ST_SEND_SKP);
         r_ack    <= (w_state_nxt == ST_SEND_OS) && (w_cnt_nxt == w_len_nxt);
         r_grant  <= (w_state_nxt == ST_PKT);
         r_pend   <= w_pend_nxt;
         if (!linkUp || w_expire) begin
            r_timer <= 12'd0;
         end else begin
            r_timer <= r_timer + 12'd1;
         end
      end
   end

   assign osStart    = r_start;
   assign osActive   = r_active;
   assign osSel      = r_sel;
   assign osAck      = r_ack;
   assign pktGrant   = r_grant;
   assign skpPending = r_pend;

endmodule

// File: tb/tb_os_tx_scheduler.sv
// tb/tb_os_tx_scheduler.sv - self-checking bench for os_tx_scheduler
module tb_os_tx_scheduler;
   localparam int INTERVAL = 100;
   localparam int K_IDLE = 0;
   localparam int K_OS   = 1;
   localparam int K_SKP  = 2;
   localparam int K_PKT  = 3;
`ifdef OS_SKP_DEBT_EN
   localparam int DEBT_MAX = 3;
`else
   localparam int DEBT_MAX = 1;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] gen;
   logic       linkUp;
   logic       osReq;
   logic [1:0] osType;
   logic       pktReq;
   logic       pktEnd;
   logic       osStart;
   logic       osActive;
   logic [1:0] osSel;
   logic       osAck;
   logic       pktGrant;
   logic       skpPending;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   // Reference model: activity described by kind plus absolute start cycle and length.
   int         m_kind;
   int         m_start;
   int         m_len;
   logic [1:0] m_type;
   int         m_tcnt;
   int         m_debt;
   logic       e_start, e_active, e_ack, e_grant, e_pend;
   logic [1:0] e_sel;

   always #5 clk = ~clk;

   os_tx_scheduler #(
      .GEN1_PIPEWIDTH(64),
      .GENX_PIPEWIDTH(8),
      .SKP_INTERVAL  (INTERVAL)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .gen       (gen),
      .linkUp    (linkUp),
      .osReq     (osReq),
      .osType    (osType),
      .pktReq    (pktReq),
      .pktEnd    (pktEnd),
      .osStart   (osStart),
      .osActive  (osActive),
      .osSel     (osSel),
      .osAck     (osAck),
      .pktGrant  (pktGrant),
      .skpPending(skpPending)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int set_len(input logic [2:0] g);
      return (g >= 3'd2 && g <= 3'd5) ? 16 : 2;
   endfunction

   task automatic model_reset();
      m_kind = K_IDLE; m_start = 0; m_len = 0; m_type = 2'b00;
      m_tcnt = 0; m_debt = 0;
      e_start = 0; e_active = 0; e_ack = 0; e_grant = 0; e_pend = 0; e_sel = 2'b00;
   endtask

   // Inputs seen at the end of cycle 'cyc' decide what cycle cyc+1 looks like.
   task automatic model_step();
      int nk, ns, nl, nd;
      logic [1:0] nt;
      bit expire, done;
      nk = m_kind; ns = m_start; nl = m_len; nt = m_type;
      expire = linkUp && (m_tcnt == INTERVAL - 1);
      case (m_kind)
         K_IDLE: begin
            if (m_debt > 0 && linkUp) begin
               nk = K_SKP; ns = cyc + 1; nl = set_len(gen); nt = 2'b10;
            end else if (osReq) begin
               nk = K_OS; ns = cyc + 1; nl = set_len(gen); nt = osType;
            end else if (pktReq && linkUp) begin
               nk = K_PKT;
            end
         end
         K_OS:  if (cyc == m_start + m_len - 1) nk = K_IDLE;
         K_SKP: if (!linkUp || cyc == m_start + m_len - 1) nk = K_IDLE;
         default: if (pktEnd || !linkUp) nk = K_IDLE;
      endcase
      done = (nk == K_SKP) && (cyc + 1 == ns + nl - 1);
      if (!linkUp) nd = 0;
      else begin
         nd = m_debt - (done ? 1 : 0) + (expire ? 1 : 0);
         if (nd > DEBT_MAX) nd = DEBT_MAX;
      end
      m_tcnt   = (!linkUp || expire) ? 0 : m_tcnt + 1;
      m_debt   = nd;
      m_kind   = nk; m_start = ns; m_len = nl; m_type = nt;
      e_active = (nk == K_OS) || (nk == K_SKP);
      e_start  = e_active && (cyc + 1 == ns);
      e_ack    = (nk == K_OS) && (cyc + 1 == ns + nl - 1);
      e_grant  = (nk == K_PKT);
      e_sel    = nt;
      e_pend   = (nd > 0);
   endtask

   task automatic compare_outputs();
      check("osStart", osStart, e_start);
      check("osActive", osActive, e_active);
      if (e_active) check("osSel", osSel, e_sel);
      check("osAck", osAck, e_ack);
      check("pktGrant", pktGrant, e_grant);
      check("skpPending", skpPending, e_pend);
   endtask

   task automatic step();
      @(posedge clk);
      if (reset) model_step();
      else model_reset();
      cyc++;
      #1;
      compare_outputs();
   endtask

   // Asserts reset away from a clock edge, checks the asynchronous clear, holds two edges.
   task automatic apply_reset();
      reset = 1'b0;
      model_reset();
      #1;
      compare_outputs();
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks, grants, bad, act, ack_at, rise, first_skp, overlap, skps, found;
      logic [1:0] sels[$];

      reset = 1'b1; gen = 3'b001; linkUp = 0; osReq = 0; osType = 0; pktReq = 0; pktEnd = 0;
      model_reset();
      #2;

      // Held TS1 requests with the link down: 2-cycle sets, ack every third cycle.
      gen = 3'b001; linkUp = 0; osReq = 1; osType = 2'b00;
      apply_reset();
      acks = 0; grants = 0; bad = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (osAck) begin
            acks++;
            if (i % 3 != 1) bad++;
         end
         grants += int'(pktGrant);
      end
      check("ts1_ack_count", acks, 10);
      check("ts1_ack_phase", bad, 0);
      check("ts1_no_grant", grants, 0);

      // Single-cycle request pulse at gen 010: 16-cycle TS2, one ack in its last cycle.
      osReq = 0;
      apply_reset();
      gen = 3'b010; osType = 2'b01; osReq = 1;
      act = 0; acks = 0; ack_at = 0; bad = 0;
      for (int i = 0; i < 22; i++) begin
         step();
         if (i == 0) osReq = 0;
         if (osActive) begin
            act++;
            if (osSel != 2'b01) bad++;
         end
         if (osAck) begin
            acks++;
            ack_at = act;
         end
      end
      check("ts2_active_len", act, 16);
      check("ts2_ack_count", acks, 1);
      check("ts2_ack_pos", ack_at, 16);
      check("ts2_sel", bad, 0);

      // SKP becomes due mid-packet and is sent only after the packet ends.
      gen = 3'b001; linkUp = 1; pktReq = 1; pktEnd = 0; osReq = 0;
      apply_reset();
      rise = -1; first_skp = -1; overlap = 0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (skpPending && rise < 0) rise = i;
         if (osActive && pktGrant) overlap++;
         if (osStart && osSel == 2'b10 && first_skp < 0) first_skp = i;
         if (i == 149) pktEnd = 1;
         if (i == 150) begin pktEnd = 0; pktReq = 0; end
      end
      check("skp_pending_rise", rise, 100);
      check("skp_after_pkt", first_skp, 151);
      check("skp_pkt_overlap", overlap, 0);

      // Pending SKP and LTSSM request in the same IDLE cycle: SKP goes first.
      linkUp = 1; pktReq = 0;
      apply_reset();
      found = 0;
      for (int i = 0; i < 150 && found == 0; i++) begin
         step();
         if (skpPending) found = 1;
      end
      check("prio_pending_seen", found, 1);
      osReq = 1; osType = 2'b00;
      sels.delete();
      for (int i = 0; i < 40; i++) begin
         step();
         if (osStart) sels.push_back(osSel);
         if (osAck) osReq = 0;
      end
      check("prio_set_count", sels.size(), 2);
      if (sels.size() >= 2) begin
         check("prio_first_skp", sels[0], 2'b10);
         check("prio_second_ts1", sels[1], 2'b00);
      end

      // Link drop in the fifth cycle of a gen 011 SKP aborts it and restarts the timer.
      gen = 3'b011; linkUp = 1; osReq = 0; pktReq = 0;
      apply_reset();
      found = 0;
      for (int i = 0; i < 150 && found == 0; i++) begin
         step();
         if (osStart && osSel == 2'b10) found = 1;
      end
      check("abort_skp_started", found, 1);
      for (int i = 0; i < 4; i++) step();
      linkUp = 0;
      step();
      check("abort_active", osActive, 1'b0);
      check("abort_pending", skpPending, 1'b0);
      linkUp = 1;
      rise = -1;
      for (int i = 1; i <= 110 && rise < 0; i++) begin
         step();
         if (skpPending) rise = i;
      end
      check("abort_timer_restart", rise, 100);

      // Long packet spanning several expiries: owed SKPs drained afterwards.
      gen = 3'b001; linkUp = 1; pktReq = 1; pktEnd = 0;
      apply_reset();
      skps = 0; bad = 0;
      for (int i = 1; i <= 460; i++) begin
         step();
         if (osStart && osSel == 2'b10) begin
            if (i > 400) skps++;
            else bad++;
         end
         if (i == 399) pktEnd = 1;
         if (i == 400) begin pktEnd = 0; pktReq = 0; end
      end
      check("debt_skp_count", skps, DEBT_MAX);
      check("debt_no_skp_in_pkt", bad, 0);

      // Randomized traffic against the model, with occasional mid-transfer resets.
      linkUp = 1; osReq = 0; pktReq = 0; pktEnd = 0;
      apply_reset();
      for (int i = 0; i < 3000; i++) begin
         step();
         if ($urandom_range(0, 199) == 0) apply_reset();
         if (linkUp) begin
            if ($urandom_range(0, 99) == 0) linkUp = 0;
         end else if ($urandom_range(0, 7) == 0) linkUp = 1;
         if ($urandom_range(0, 49) == 0) gen = 3'($urandom_range(0, 7));
         if (osReq) begin
            if (e_ack || $urandom_range(0, 63) == 0) osReq = 0;
         end else if ($urandom_range(0, 9) == 0) begin
            osReq = 1;
            osType = 2'($urandom_range(0, 3));
         end
         pktReq = ($urandom_range(0, 3) == 0);
         pktEnd = ($urandom_range(0, 4) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
